imem_arbiter: RTL and testbench

- Sequencer and arbiter sharing the single-port byte-addressed instruction memory (4096 x 8, big-endian 32-bit words, async read, sync write) between two requesters: the boot program loader (burst writes) and the pipeline fetch stage (reads).
- Drives the memory's Address/D_In/im_cs/im_wr/im_rd and returns registered fetch data with a valid pulse.
- Stalls fetch while a load burst owns memory.

---
 rtl/imem_pkg.sv | 21 ++
 rtl/imem_ld_counter.sv | 54 +++++
 rtl/imem_arbiter.sv | 178 +++++++++++++++++
 tb/tb_imem_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory arbiter.
// Optional build macro used by this slice: IMEM_ARB_ALIGN_CHECK_EN.
package imem_pkg;

    localparam int ADDR_W_DEF = 12;   // byte address width of the instruction memory
    localparam int DATA_W_DEF = 32;   // instruction word width
    localparam int CNT_W_DEF  = 11;   // loaded-word counter width
    localparam int WORD_BYTES = 4;    // bytes per instruction word

    // IDLE : no memory activity in flight
    // FETCH: a read issued last cycle is on the memory bus now
    // DRAIN: loader waiting one cycle for an in-flight read to land
    // LOAD : loader owns the memory until it delivers its last word
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        LOAD  = 2'd2,
        DRAIN = 2'd3
    } arb_state_e;

endpackage

// File: rtl/imem_ld_counter.sv
// Loader write-address generator and saturating word counter.
// Both restart on a grant; each accepted word advances the address by one
// word, wrapping inside the memory, and bumps the count until it is all-ones.
module imem_ld_counter
    import imem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic [ADDR_W-1:0] base,
    input  logic              step,
    output logic [ADDR_W-1:0] addr,
    output logic [CNT_W-1:0]  count
);

    logic [ADDR_W-1:0] addr_d,  addr_q;
    logic [CNT_W-1:0]  count_d, count_q;

    // Next address/count: restart on grant, advance on each accepted word.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        addr_d  = addr_q;
        count_d = count_q;
        if (load) begin
            addr_d  = base;
            count_d = '0;
        end else if (step) begin
            // The ADDR_W-bit sum drops its carry, which is the wrap to address 0.
            addr_d = addr_q + ADDR_W'(WORD_BYTES);
            if (count_q != '1) begin
                count_d = count_q + CNT_W'(1);
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (!reset_n) begin
            addr_q  <= '0;
            count_q <= '0;
        end else begin
            addr_q  <= addr_d;
            count_q <= count_d;
        end
    end

    assign addr  = addr_q;
    assign count = count_q;

endmodule

// File: rtl/imem_arbiter.sv
// Shares the single-port instruction memory between the boot loader (burst
// writes) and the fetch stage (reads). All memory-side outputs are registered;
// fetch data returns two cycles after acceptance with a one-cycle valid pulse.
// Build macro IMEM_ARB_ALIGN_CHECK_EN: misaligned fetches are consumed without
// a memory access and flagged on if_err; loader base is forced word-aligned.
module imem_arbiter
    import imem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_base,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_wdata,
    input  logic              ld_last,
    output logic              ld_ready,
    output logic [CNT_W-1:0]  ld_count,
    output logic              ld_done,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_stall,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    output logic              if_err,
    output logic [ADDR_W-1:0] Address,
    output logic [DATA_W-1:0] D_In,
    input  logic [DATA_W-1:0] D_Out,
    output logic              im_cs,
    output logic              im_wr,
    output logic              im_rd
);

    arb_state_e        state_d, state_q;
    logic [ADDR_W-1:0] address_d, address_q;
    logic [DATA_W-1:0] d_in_d, d_in_q;
    logic              cs_d, cs_q, wr_d, wr_q, rd_d, rd_q;
    logic [DATA_W-1:0] if_rdata_d, if_rdata_q;
    logic              if_valid_d, if_valid_q;
    logic              ld_done_d, ld_done_q;
    logic              err_p1_d, err_p1_q;
    logic              if_err_d, if_err_q;
    logic              cnt_load, cnt_step;
    logic [ADDR_W-1:0] cnt_addr, ld_base_eff;
    logic              misaligned;

`ifdef IMEM_ARB_ALIGN_CHECK_EN
    assign misaligned  = |if_addr[1:0];
    assign ld_base_eff = ld_base & ~ADDR_W'(WORD_BYTES - 1);
`else
    assign misaligned  = 1'b0;
    assign ld_base_eff = ld_base;
`endif

    imem_ld_counter #(
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) u_ld_counter (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (cnt_load),
        .base    (ld_base_eff),
        .step    (cnt_step),
        .addr    (cnt_addr),
        .count   (ld_count)
    );

    // Arbitration, memory command generation and fetch-return pipeline.
    always_comb begin
        state_d    = state_q;
        address_d  = address_q;   // address and write data hold when idle
        d_in_d     = d_in_q;
        cs_d       = 1'b0;
        wr_d       = 1'b0;
        rd_d       = 1'b0;
        if_rdata_d = if_rdata_q;
        if_valid_d = 1'b0;
        ld_done_d  = 1'b0;
        err_p1_d   = 1'b0;
        if_err_d   = err_p1_q;
        cnt_load   = 1'b0;
        cnt_step   = 1'b0;

        // A read driven this cycle lands in if_rdata at the edge ending it.
        if (rd_q) begin
            if_rdata_d = D_Out;
            if_valid_d = 1'b1;
        end

        unique case (state_q)
            IDLE, FETCH: begin
                if (ld_req) begin
                    // Loader wins; a read still on the bus must land first.
                    if (state_q == FETCH) begin
                        state_d = DRAIN;
                    end else begin
                        state_d  = LOAD;
                        cnt_load = 1'b1;
                    end
                end else if (if_req && misaligned) begin
                    err_p1_d = 1'b1;
                    state_d  = IDLE;
                end else if (if_req) begin
                    cs_d      = 1'b1;
                    rd_d      = 1'b1;
                    address_d = if_addr;
                    state_d   = FETCH;
                end else begin
                    state_d = IDLE;
                end
            end
            DRAIN: begin
                state_d  = LOAD;
                cnt_load = 1'b1;
            end
            LOAD: begin
                // Only ld_last ends a burst; ld_req is not looked at here.
                if (ld_valid) begin
                    cs_d      = 1'b1;
                    wr_d      = 1'b1;
                    address_d = cnt_addr;
                    d_in_d    = ld_wdata;
                    cnt_step  = 1'b1;
                    if (ld_last) begin
                        ld_done_d = 1'b1;
                        state_d   = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            address_q  <= '0;
            d_in_q     <= '0;
            cs_q       <= 1'b0;
            wr_q       <= 1'b0;
            rd_q       <= 1'b0;
            if_rdata_q <= '0;
            if_valid_q <= 1'b0;
            ld_done_q  <= 1'b0;
            err_p1_q   <= 1'b0;
            if_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            address_q  <= address_d;
            d_in_q     <= d_in_d;
            cs_q       <= cs_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            if_rdata_q <= if_rdata_d;
            if_valid_q <= if_valid_d;
            ld_done_q  <= ld_done_d;
            err_p1_q   <= err_p1_d;
            if_err_q   <= if_err_d;
        end
    end

    assign Address  = address_q;
    assign D_In     = d_in_q;
    assign im_cs    = cs_q;
    assign im_wr    = wr_q;
    assign im_rd    = rd_q;
    assign if_rdata = if_rdata_q;
    assign if_valid = if_valid_q;
    assign if_err   = if_err_q;
    assign ld_done  = ld_done_q;
    assign ld_ready = (state_q == LOAD);
    assign if_stall = (state_q == LOAD) || (state_q == DRAIN) || ld_req;

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed plus randomized bench for imem_arbiter. A byte-level golden image
// of the instruction memory is updated from the loader rules (word i of a
// burst lands big-endian at (base + 4*i) mod 4096) and fetch data is
// predicted from that image.
module tb_imem_arbiter;

    localparam int MEM_BYTES = 4096;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ld_req = 1'b0;
    logic [11:0] ld_base = '0;
    logic        ld_valid = 1'b0;
    logic [31:0] ld_wdata = '0;
    logic        ld_last = 1'b0;
    logic        ld_ready;
    logic [10:0] ld_count;
    logic        ld_done;
    logic        if_req = 1'b0;
    logic [11:0] if_addr = '0;
    logic        if_stall;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        if_err;
    logic [11:0] Address;
    logic [31:0] D_In;
    logic [31:0] D_Out;
    logic        im_cs, im_wr, im_rd;

    int total = 0;
    int bad   = 0;

    logic [7:0]  mem  [MEM_BYTES];   // the memory device seen by the DUT
    logic [7:0]  gold [MEM_BYTES];   // expected memory image
    logic [31:0] wq [$];             // words of the next burst
    logic [11:0] faddr [$];          // addresses of the next fetch stream
    logic [31:0] last_rd = '0;       // expected if_rdata after the last fetch

    imem_arbiter dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .ld_req   (ld_req),
        .ld_base  (ld_base),
        .ld_valid (ld_valid),
        .ld_wdata (ld_wdata),
        .ld_last  (ld_last),
        .ld_ready (ld_ready),
        .ld_count (ld_count),
        .ld_done  (ld_done),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_stall (if_stall),
        .if_rdata (if_rdata),
        .if_valid (if_valid),
        .if_err   (if_err),
        .Address  (Address),
        .D_In     (D_In),
        .D_Out    (D_Out),
        .im_cs    (im_cs),
        .im_wr    (im_wr),
        .im_rd    (im_rd)
    );

    always #5 clk = ~clk;

    // Memory device: asynchronous big-endian read, synchronous write.
    assign D_Out = {mem[Address], mem[Address + 12'd1], mem[Address + 12'd2], mem[Address + 12'd3]};
    always @(posedge clk) begin
        if (im_cs && im_wr) begin
            mem[Address]         <= D_In[31:24];
            mem[Address + 12'd1] <= D_In[23:16];
            mem[Address + 12'd2] <= D_In[15:8];
            mem[Address + 12'd3] <= D_In[7:0];
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [31:0] gold_rd(input logic [11:0] a);
        return {gold[a], gold[a + 12'd1], gold[a + 12'd2], gold[a + 12'd3]};
    endfunction

    task automatic gold_wr(input logic [11:0] a, input logic [31:0] w);
        gold[a]         = w[31:24];
        gold[a + 12'd1] = w[23:16];
        gold[a + 12'd2] = w[15:8];
        gold[a + 12'd3] = w[7:0];
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ctl"}, {ld_ready, ld_done, if_stall, if_valid, if_err, im_cs, im_wr, im_rd}, 0);
        chk({tag, "_addr"}, Address, 0);
        chk({tag, "_din"}, D_In, 0);
        chk({tag, "_rdata"}, if_rdata, 0);
        chk({tag, "_count"}, ld_count, 0);
    endtask

    // Runs one burst of wq words from base. abort_at >= 0 pulls reset once
    // that many words have been written. hold_if: a fetch is pending the whole
    // time. drain: a read was issued the cycle before ld_req rises.
    task automatic load_burst(input logic [11:0] base, input int abort_at,
                              input bit hold_if, input bit drain);
        int n;
        logic [11:0] exp_a;
        n = wq.size();
        ld_req  = 1'b1;
        ld_base = base;
        #1 chk("req_stall", if_stall, 1);
        if (drain) begin
            tick;
            chk("drain_valid", if_valid, 1);
            chk("drain_rdata", if_rdata, gold_rd(if_addr));
            chk("drain_ctl", {im_cs, im_rd, ld_ready}, 0);
            last_rd = gold_rd(if_addr);
        end
        tick;
        chk("grant_ready", ld_ready, 1);
        chk("grant_rd", im_rd, 0);
        ld_req = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (i == abort_at) begin
                ld_valid = 1'b0;
                tick;
                reset_n = 1'b0;
                #1 chk_zero("abort");
                tick;
                chk_zero("abort_hold");
                reset_n = 1'b1;
                tick;
                return;
            end
            if ($urandom_range(0, 3) == 0) begin
                ld_valid = 1'b0;
                tick;
                chk("gap_ctl", {im_cs, im_wr, im_rd}, 0);
                chk("gap_ready", ld_ready, 1);
            end
            ld_valid = 1'b1;
            ld_wdata = wq[i];
            ld_last  = (i == n - 1);
            if (hold_if) begin
                #1 chk("load_stall", if_stall, 1);
            end
            tick;
            exp_a = 12'((int'(base) + 4 * i) % MEM_BYTES);
            chk("wr_ctl", {im_cs, im_wr, im_rd}, 3'b110);
            chk("wr_addr", Address, exp_a);
            chk("wr_data", D_In, wq[i]);
            chk("ld_count", ld_count, i + 1);
            chk("ld_done", ld_done, (i == n - 1) ? 1 : 0);
            gold_wr(exp_a, wq[i]);
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        if (!hold_if) begin
            tick;
            chk("done_clear", {ld_done, im_wr, ld_ready}, 0);
        end
    endtask

    // Back-to-back reads of faddr; checks command cycle and data two cycles on.
    task automatic fetch_stream;
        int n;
        n = faddr.size();
        for (int k = 0; k <= n + 1; k++) begin
            if (k < n) begin
                if_req  = 1'b1;
                if_addr = faddr[k];
                #1 chk("if_stall", if_stall, 0);
            end else begin
                if_req = 1'b0;
            end
            tick;
            chk("rd_ctl", {im_cs, im_wr, im_rd}, (k < n) ? 3'b101 : 3'b000);
            if (k < n) chk("rd_addr", Address, faddr[k]);
            chk("if_valid", if_valid, (k >= 1 && k <= n) ? 1 : 0);
            chk("if_err", if_err, 0);
            if (k >= 1 && k <= n) chk("if_rdata", if_rdata, gold_rd(faddr[k - 1]));
        end
        last_rd = gold_rd(faddr[n - 1]);
    endtask

    initial begin
        int nw;
        logic [11:0] base;
        for (int i = 0; i < MEM_BYTES; i++) begin
            mem[i]  = 8'h00;
            gold[i] = 8'h00;
        end

        // Reset state
        #3 chk_zero("reset");
        tick;
        reset_n = 1'b1;
        tick;
        chk_zero("idle");

        // Directed three-word program at 0x000
        wq = '{32'h20080005, 32'h20090007, 32'h01095020};
        load_burst(12'h000, -1, 1'b0, 1'b0);

        // Back-to-back fetches of the loaded program
        faddr = '{12'h000, 12'h004, 12'h008};
        fetch_stream();

        // Simultaneous ld_req and if_req: loader first, then the fetch
        wq = '{$urandom(), $urandom()};
        if_req  = 1'b1;
        if_addr = 12'h040;
        load_burst(12'h040, -1, 1'b1, 1'b0);
        faddr = '{12'h040};
        fetch_stream();

        // Loader request while a read is in flight
        if_req  = 1'b1;
        if_addr = 12'h004;
        tick;
        if_req = 1'b0;
        wq = '{$urandom(), $urandom(), $urandom()};
        load_burst(12'h200, -1, 1'b0, 1'b1);
        faddr = '{12'h200, 12'h204, 12'h208};
        fetch_stream();

        // Burst crossing the top of memory
        wq = '{$urandom(), $urandom()};
        load_burst(12'hFFC, -1, 1'b0, 1'b0);
        faddr = '{12'hFFC, 12'h000};
        fetch_stream();

        // Reset after two of four words
        wq = '{$urandom(), $urandom(), $urandom(), $urandom()};
        load_burst(12'h000, 2, 1'b0, 1'b0);
        chk("post_abort_count", ld_count, 0);
        chk("post_abort_done", ld_done, 0);
        faddr = '{12'h000, 12'h004, 12'h008};
        fetch_stream();

`ifdef IMEM_ARB_ALIGN_CHECK_EN
        // Misaligned fetch is consumed and flagged without a memory access
        if_req  = 1'b1;
        if_addr = 12'h006;
        #1 chk("mis_stall", if_stall, 0);
        tick;
        if_req = 1'b0;
        chk("mis_ctl", {im_cs, im_wr, im_rd}, 0);
        tick;
        chk("mis_err", if_err, 1);
        chk("mis_valid", if_valid, 0);
        chk("mis_rdata", if_rdata, last_rd);
        tick;
        chk("mis_err_clear", if_err, 0);
`else
        // Misaligned fetch passes straight through to the memory
        faddr = '{12'h006};
        fetch_stream();
`endif

        // Randomized bursts followed by fetch streams
        for (int r = 0; r < 6; r++) begin
            nw   = $urandom_range(1, 6);
            base = 12'($urandom_range(0, 1023) * 4);
            wq.delete();
            for (int j = 0; j < nw; j++) wq.push_back($urandom());
            if (r % 2 == 1) begin
                if_req  = 1'b1;
                if_addr = base;
                load_burst(base, -1, 1'b1, 1'b0);
                faddr = '{base};
                fetch_stream();
            end else begin
                load_burst(base, -1, 1'b0, 1'b0);
            end
            faddr.delete();
            for (int j = 0; j < $urandom_range(1, 5); j++) begin
                if ($urandom_range(0, 1) == 0)
                    faddr.push_back(12'((int'(base) + 4 * $urandom_range(0, nw - 1)) % MEM_BYTES));
                else
                    faddr.push_back(12'($urandom_range(0, 1023) * 4));
            end
            fetch_stream();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
